// File: rtl/usb1bd_rx_phy_pkg.sv
// Shared types and constants for the full-speed USB receive PHY.
// Receive FSM states and the {D-, D+} line-state encodings.
package usb1bd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DATA  = 2'd2,
        ABORT = 2'd3
    } rx_state_t;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    // NRZI: no transition between bit strobes encodes a 1.
    function automatic logic nrzi_bit(input logic cur, input logic prev);
        return cur == prev;
    endfunction

endpackage

// File: rtl/usb1bd_rx_phy_if.sv
// UTMI-style receive byte stream between the PHY and the packet disassembler.
interface usb1bd_rx_phy_if;

    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_err;
    logic [1:0] line_state;

    modport master (
        input  rx_en,
        output rx_data, rx_valid, rx_active, rx_err, line_state
    );

    modport slave (
        output rx_en,
        input  rx_data, rx_valid, rx_active, rx_err, line_state
    );

endinterface

// File: rtl/usb1bd_rx_dpll.sv
// Line synchronisers and 4x oversampling bit-clock recovery.
// A strobe marks the sample point roughly mid-bit after each detected edge.
module usb1bd_rx_dpll
    import usb1bd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rxdp,
    input  logic       rxdn,
    output logic       strobe,
    output logic       rxd_s,
    output logic       se0_s,
    output logic       se1_s,
    output logic [1:0] line_state
);

    logic [1:0] rxd_sync_q;
    logic [1:0] dp_sync_q;
    logic [1:0] dn_sync_q;
    logic [1:0] prev_q;
    logic [1:0] phase_q;
    logic [1:0] phase_d;
    logic       line_edge;

    assign rxd_s      = rxd_sync_q[1];
    assign line_state = {dn_sync_q[1], dp_sync_q[1]};
    assign se0_s      = (line_state == LS_SE0);
    assign se1_s      = (line_state == LS_SE1);
    assign line_edge  = ({rxd_s, se0_s} != prev_q);
    assign strobe     = (phase_q == 2'd1);

    always_comb begin
        phase_d = phase_q + 2'd1;
        if (line_edge) begin
            phase_d = 2'd0;
        end
    end

    // Synchronisers reset to the idle J state so line_state reads J out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_sync_q <= 2'b11;
            dp_sync_q  <= 2'b11;
            dn_sync_q  <= 2'b00;
            prev_q     <= 2'b10;
            phase_q    <= 2'd0;
        end else begin
            rxd_sync_q <= {rxd_sync_q[0], rxd};
            dp_sync_q  <= {dp_sync_q[0], rxdp};
            dn_sync_q  <= {dn_sync_q[0], rxdn};
            prev_q     <= {rxd_s, se0_s};
            phase_q    <= phase_d;
        end
    end

endmodule

// File: rtl/usb1bd_rx_phy.sv
// Full-speed USB receive PHY: NRZI decode, SYNC/EOP detection, bit-unstuffing
// and LSB-first byte assembly on top of the recovered bit strobe.
module usb1bd_rx_phy
    import usb1bd_pkg::*;
#(
    parameter int ABORT_IDLE_BITS = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rxd,
    input  logic            rxdp,
    input  logic            rxdn,
    usb1bd_rx_phy_if.master rx_if
);

    localparam int CW = (ABORT_IDLE_BITS < 2) ? 1 : $clog2(ABORT_IDLE_BITS + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(ABORT_IDLE_BITS - 1);
    localparam logic [CW-1:0] IDLE_ONE  = CW'(1);

    logic       strobe;
    logic       rxd_s;
    logic       se0_s;
    logic       se1_s;
    logic [1:0] line_state;

    rx_state_t     state_q, state_d;
    logic          prev_rxd_q, prev_rxd_d;
    logic [2:0]    ones_q, ones_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          se0_seen_q, se0_seen_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_active_q, rx_active_d;
    logic          rx_err_q, rx_err_d;

    logic          is_j;
    logic          is_k;
    logic          dbit;

    usb1bd_rx_dpll u_dpll (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rxdp       (rxdp),
        .rxdn       (rxdn),
        .strobe     (strobe),
        .rxd_s      (rxd_s),
        .se0_s      (se0_s),
        .se1_s      (se1_s),
        .line_state (line_state)
    );

    assign is_j = !se0_s && !se1_s &&  rxd_s;
    assign is_k = !se0_s && !se1_s && !rxd_s;
    assign dbit = nrzi_bit(rxd_s, prev_rxd_q);

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.rx_active  = rx_active_q;
    assign rx_if.rx_err     = rx_err_q;
    assign rx_if.line_state = line_state;

    always_comb begin
        state_d     = state_q;
        prev_rxd_d  = prev_rxd_q;
        ones_d      = ones_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        se0_seen_d  = se0_seen_q;
        idle_cnt_d  = idle_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_active_d = rx_active_q;
        rx_err_d    = 1'b0;

        if (strobe && !se0_s && !se1_s) begin
            prev_rxd_d = rxd_s;
        end

        unique case (state_q)
            IDLE: begin
                se0_seen_d = 1'b0;
                if (strobe && is_k && rx_if.rx_en) begin
                    state_d = SYNC;
                end
            end

            SYNC: begin
                if (!rx_if.rx_en) begin
                    state_d = IDLE;
                end else if (strobe) begin
                    if (se0_s || se1_s) begin
                        state_d = IDLE;
                    end else if (dbit) begin
                        // The closing KK of SYNC is a 1 and seeds the stuff counter.
                        state_d     = DATA;
                        rx_active_d = 1'b1;
                        ones_d      = 3'd1;
                        bitcnt_d    = 3'd0;
                        se0_seen_d  = 1'b0;
                    end
                end
            end

            DATA: begin
                if (!rx_if.rx_en) begin
                    state_d     = ABORT;
                    rx_active_d = 1'b0;
                    idle_cnt_d  = '0;
                    se0_seen_d  = 1'b0;
                end else if (strobe) begin
                    if (se1_s || (!se0_s && !se0_seen_q && ones_q == 3'd6 && dbit)) begin
                        state_d     = ABORT;
                        rx_active_d = 1'b0;
                        rx_err_d    = 1'b1;
                        idle_cnt_d  = '0;
                        se0_seen_d  = 1'b0;
                    end else if (se0_s) begin
                        se0_seen_d = 1'b1;
                    end else if (se0_seen_q) begin
                        // End of packet; any dribble bits in the shifter are dropped.
                        state_d     = is_j ? IDLE : ABORT;
                        rx_active_d = 1'b0;
                        idle_cnt_d  = '0;
                        se0_seen_d  = 1'b0;
                    end else if (ones_q == 3'd6) begin
                        ones_d = 3'd0;
                    end else begin
                        ones_d   = dbit ? (ones_q + 3'd1) : 3'd0;
                        shift_d  = {dbit, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rx_data_d  = {dbit, shift_q[7:1]};
                            rx_valid_d = 1'b1;
                        end
                    end
                end
            end

            ABORT: begin
                if (strobe) begin
                    if (se0_s) begin
                        se0_seen_d = 1'b1;
                        idle_cnt_d = '0;
                    end else if (is_j) begin
                        if (se0_seen_q || idle_cnt_q == IDLE_LAST) begin
                            state_d    = IDLE;
                            idle_cnt_d = '0;
                        end else begin
                            idle_cnt_d = idle_cnt_q + IDLE_ONE;
                        end
                    end else begin
                        idle_cnt_d = '0;
                        se0_seen_d = 1'b0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_rxd_q  <= 1'b1;
            ones_q      <= 3'd0;
            bitcnt_q    <= 3'd0;
            se0_seen_q  <= 1'b0;
            idle_cnt_q  <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_rxd_q  <= prev_rxd_d;
            ones_q      <= ones_d;
            bitcnt_q    <= bitcnt_d;
            se0_seen_q  <= se0_seen_d;
            idle_cnt_q  <= idle_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_active_q <= rx_active_d;
            rx_err_q    <= rx_err_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_usb1bd_rx_phy.sv
// Directed bench for usb1bd_rx_phy: an NRZI/stuffing line driver feeds packets,
// a monitor pops expected bytes/errors from a scoreboard queue as they appear.
module tb_usb1bd_rx_phy;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic rxdp;
    logic rxdn;

    usb1bd_rx_phy_if rx_if();

    usb1bd_rx_phy #(.ABORT_IDLE_BITS(7)) dut (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rxdp  (rxdp),
        .rxdn  (rxdn),
        .rx_if (rx_if)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_vld = -100;
    logic act_prev = 1'b0;
    logic saw_active = 1'b0;

    logic lvl_j = 1'b1;
    int   ones = 0;
    bit   jit = 1'b0;
    bit   jphase = 1'b0;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (rx_if.rx_valid) begin
                checks++;
                if (!rx_if.rx_active) begin
                    errors++;
                    $display("FAIL valid_while_active: rx_active=%0b required 1", rx_if.rx_active);
                end
                checks++;
                if (cyc - last_vld < 3) begin
                    errors++;
                    $display("FAIL valid_spacing: gap=%0d required >=3", cyc - last_vld);
                end
                last_vld = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: rx_data=%h required no byte", rx_if.rx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_err || rx_if.rx_data !== mon_e.data) begin
                        errors++;
                        $display("FAIL byte: rx_data=%h required %h (err_expected=%0b)",
                                 rx_if.rx_data, mon_e.data, mon_e.is_err);
                    end
                end
            end
            if (rx_if.rx_err) begin
                checks++;
                if (rx_if.rx_active || !act_prev) begin
                    errors++;
                    $display("FAIL err_active_fall: rx_active=%0b prev=%0b required 0/1",
                             rx_if.rx_active, act_prev);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_err: rx_err=1 required 0");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e.is_err) begin
                        errors++;
                        $display("FAIL err_order: got rx_err required byte %h", mon_e.data);
                    end
                end
            end
            if (rx_if.rx_active) saw_active = 1'b1;
        end
        act_prev = rx_if.rx_active;
    end

    // ---------------- line driver ----------------
    function automatic int bit_period();
        if (jit) begin
            jphase = !jphase;
            return jphase ? 3 : 5;
        end
        return 4;
    endfunction

    // kind: 0 = J, 1 = K, 2 = SE0
    task automatic drive_line(input int kind, input int n);
        case (kind)
            0: begin rxd = 1'b1; rxdp = 1'b1; rxdn = 1'b0; end
            1: begin rxd = 1'b0; rxdp = 1'b0; rxdn = 1'b1; end
            default: begin rxd = 1'b0; rxdp = 1'b0; rxdn = 1'b0; end
        endcase
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_nrzi(input bit b);
        if (!b) lvl_j = !lvl_j;
        drive_line(lvl_j ? 0 : 1, bit_period());
    endtask

    task automatic tx_sync();
        lvl_j = 1'b1;
        for (int i = 0; i < 7; i++) tx_nrzi(1'b0);
        tx_nrzi(1'b1);
        ones = 1;
    endtask

    task automatic tx_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            tx_nrzi(v[i]);
            ones = v[i] ? ones + 1 : 0;
            if (ones == 6) begin
                tx_nrzi(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic tx_idle(input int nbits);
        lvl_j = 1'b1;
        drive_line(0, 4 * nbits);
    endtask

    task automatic tx_eop();
        drive_line(2, bit_period());
        drive_line(2, bit_period());
        lvl_j = 1'b1;
        drive_line(0, bit_period());
        tx_idle(6);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(ev_t'{is_err: 1'b0, data: b});
    endtask

    task automatic expect_err();
        exp_q.push_back(ev_t'{is_err: 1'b1, data: 8'h00});
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic check_done(input string name);
        check_val({name, "_pending"}, 8'(exp_q.size()), 8'h00);
        check_val({name, "_active_end"}, {7'd0, rx_if.rx_active}, 8'h00);
        exp_q.delete();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        rx_if.rx_en = 1'b1;
        drive_line(0, 4);
        check_val("rst_rx_data", rx_if.rx_data, 8'h00);
        check_val("rst_rx_valid", {7'd0, rx_if.rx_valid}, 8'h00);
        check_val("rst_rx_active", {7'd0, rx_if.rx_active}, 8'h00);
        check_val("rst_rx_err", {7'd0, rx_if.rx_err}, 8'h00);
        check_val("rst_line_state", {6'd0, rx_if.line_state}, 8'h01);
        rst = 1'b0;
        tx_idle(4);

        // Ideal bits, three bytes
        expect_byte(8'hE1); expect_byte(8'h05); expect_byte(8'h58);
        tx_sync(); tx_byte(8'hE1); tx_byte(8'h05); tx_byte(8'h58); tx_eop();
        check_done("basic");

        // Bit stuffing inside 0xFF 0xFF
        expect_byte(8'hFF); expect_byte(8'hFF);
        tx_sync(); tx_byte(8'hFF); tx_byte(8'hFF); tx_eop();
        check_done("stuff");

        // Seven ones with no stuff bit after PID 0xC3
        expect_byte(8'hC3); expect_err();
        tx_sync(); tx_byte(8'hC3);
        for (int i = 0; i < 7; i++) tx_nrzi(1'b1);
        tx_idle(7);
        check_done("stuff_err");

        // Packet right after the abort idle window must decode
        expect_byte(8'hA5);
        tx_sync(); tx_byte(8'hA5); tx_eop();
        check_done("after_abort");

        // Jittered 3/5-clock bit periods
        jit = 1'b1; jphase = 1'b0;
        expect_byte(8'h2D);
        tx_sync(); tx_byte(8'h2D); tx_eop();
        jit = 1'b0;
        check_done("jitter");

        // Truncated SYNC: K J K K
        expect_byte(8'h69); expect_byte(8'h3C);
        lvl_j = 1'b1;
        tx_nrzi(1'b0); tx_nrzi(1'b0); tx_nrzi(1'b0); tx_nrzi(1'b1);
        ones = 1;
        tx_byte(8'h69); tx_byte(8'h3C); tx_eop();
        check_done("short_sync");
        check_val("short_sync_rx_data", rx_if.rx_data, 8'h3C);

        // Receiver disabled during a packet
        rx_if.rx_en = 1'b0;
        saw_active = 1'b0;
        tx_sync(); tx_byte(8'h2D); tx_eop();
        check_val("rx_en_low_active", {7'd0, saw_active}, 8'h00);
        rx_if.rx_en = 1'b1;
        tx_idle(4);
        check_done("rx_en_low");

        // Reset in the middle of a byte
        tx_sync();
        for (int i = 0; i < 4; i++) tx_nrzi(1'b1);
        check_val("mid_active_before_rst", {7'd0, rx_if.rx_active}, 8'h01);
        lvl_j = 1'b1;
        rxd = 1'b1; rxdp = 1'b1; rxdn = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_rx_active", {7'd0, rx_if.rx_active}, 8'h00);
        check_val("mid_rst_rx_data", rx_if.rx_data, 8'h00);
        check_val("mid_rst_rx_valid", {7'd0, rx_if.rx_valid}, 8'h00);
        check_val("mid_rst_rx_err", {7'd0, rx_if.rx_err}, 8'h00);
        check_val("mid_rst_line_state", {6'd0, rx_if.line_state}, 8'h01);
        rst = 1'b0;
        tx_idle(10);
        expect_byte(8'h96);
        tx_sync(); tx_byte(8'h96); tx_eop();
        check_done("after_rst");
        check_val("after_rst_rx_data", rx_if.rx_data, 8'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
